ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage_pkg.sv | 21 ++
 rtl/ex_mem_stage_ccr_unit.sv | 58 +++++
 rtl/ex_mem_stage.sv | 98 +++++++++
 tb/tb_ex_mem_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_stage_pkg
//  Description : Shared constants for the EX/MEM pipeline stage. Holds the
//                default datapath and register-address widths, plus the bit
//                positions of the condition-code flags.
//                Flag layout in every 3-bit flag vector: [2] C, [1] N, [0] Z.
//  Revision    : 1.0  initial release
// ============================================================================
package ex_mem_stage_pkg;

   localparam int DATA_W  = 16;
   localparam int RADDR_W = 3;

   localparam int FLAG_W  = 3;
   localparam int FLAG_C  = 2;
   localparam int FLAG_N  = 1;
   localparam int FLAG_Z  = 0;

endpackage : ex_mem_stage_pkg
`default_nettype wire

// File: rtl/ex_mem_stage_ccr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ccr_unit
//  Description : Condition-code register with per-bit update, clear and a
//                single-level save/restore slot for interrupt entry / RTI.
//  Ports       : clk, rst         clock, async active-high reset
//                upd_en           ALU flag update is allowed this cycle
//                flag_in/flag_we  ALU flag values and per-bit write enables
//                flag_clr         per-bit clear (consumed by taken jumps)
//                flag_save        copy current ccr into the saved slot
//                flag_restore     reload ccr from the saved slot
//                ccr              registered condition codes
//  Revision    : 1.0  initial release
// ============================================================================
module ccr_unit
   import ex_mem_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              upd_en,
   input  logic [FLAG_W-1:0] flag_in,
   input  logic [FLAG_W-1:0] flag_we,
   input  logic [FLAG_W-1:0] flag_clr,
   input  logic              flag_save,
   input  logic              flag_restore,
   output logic [FLAG_W-1:0] ccr
);

   logic [FLAG_W-1:0] r_saved_ccr;
   logic [FLAG_W-1:0] w_accept;
   logic [FLAG_W-1:0] w_ccr_next;

   // Priority per bit: restore > accepted update > clear > hold.
   always_comb begin
      w_accept = flag_we & {FLAG_W{upd_en}};
      if (flag_restore) begin
         w_ccr_next = r_saved_ccr;
      end else begin
         w_ccr_next = (ccr & ~flag_clr & ~w_accept) | (flag_in & w_accept);
      end
   end

   // The saved slot always captures the pre-update ccr, so save+restore in
   // the same cycle naturally swaps the two registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ccr         <= '0;
         r_saved_ccr <= '0;
      end else begin
         ccr <= w_ccr_next;
         if (flag_save) begin
            r_saved_ccr <= ccr;
         end
      end
   end

endmodule : ccr_unit
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_stage
//  Description : EX->MEM pipeline register stage with stall/flush control,
//                a condition-code register and a forwarding enable.
//  Ports       : clk, rst                   clock, async active-high reset
//                ex_*                       execute-stage instruction fields
//                stall                      hold all pipeline registers
//                flush                      load a bubble (wins over stall)
//                flag_clr/save/restore      condition-code control
//                mem_*                      registered copies of ex_*
//                ccr                        condition-code register (C,N,Z)
//                fwd_en                     mem_valid & mem_reg_we
//  Revision    : 1.0  initial release
// ============================================================================
module ex_mem_stage #(
   parameter int DATA_W  = ex_mem_stage_pkg::DATA_W,
   parameter int RADDR_W = ex_mem_stage_pkg::RADDR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ex_valid,
   input  logic [DATA_W-1:0]  ex_result,
   input  logic [2:0]         ex_flag,
   input  logic [2:0]         ex_flag_we,
   input  logic [RADDR_W-1:0] ex_rd,
   input  logic               ex_reg_we,
   input  logic               ex_mem_rd,
   input  logic               ex_mem_wr,
   input  logic [DATA_W-1:0]  ex_store_data,
   input  logic               stall,
   input  logic               flush,
   input  logic [2:0]         flag_clr,
   input  logic               flag_save,
   input  logic               flag_restore,
   output logic               mem_valid,
   output logic [DATA_W-1:0]  mem_result,
   output logic [RADDR_W-1:0] mem_rd,
   output logic               mem_reg_we,
   output logic               mem_mem_rd,
   output logic               mem_mem_wr,
   output logic [DATA_W-1:0]  mem_store_data,
   output logic [2:0]         ccr,
   output logic               fwd_en
);

   import ex_mem_stage_pkg::*;

   logic w_flag_upd_en;

   // Only an instruction that actually advances into MEM may touch flags.
   assign w_flag_upd_en = ex_valid & ~stall & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_valid      <= 1'b0;
         mem_result     <= '0;
         mem_rd         <= '0;
         mem_reg_we     <= 1'b0;
         mem_mem_rd     <= 1'b0;
         mem_mem_wr     <= 1'b0;
         mem_store_data <= '0;
      end else if (flush) begin
         mem_valid      <= 1'b0;
         mem_result     <= '0;
         mem_rd         <= '0;
         mem_reg_we     <= 1'b0;
         mem_mem_rd     <= 1'b0;
         mem_mem_wr     <= 1'b0;
         mem_store_data <= '0;
      end else if (!stall) begin
         mem_valid      <= ex_valid;
         mem_result     <= ex_result;
         mem_rd         <= ex_rd;
         mem_reg_we     <= ex_reg_we;
         mem_mem_rd     <= ex_mem_rd;
         mem_mem_wr     <= ex_mem_wr;
         mem_store_data <= ex_store_data;
      end
   end

   // Derived from registered state only; no path from inputs.
   assign fwd_en = mem_valid & mem_reg_we;

   ccr_unit u_ccr_unit (
      .clk          (clk),
      .rst          (rst),
      .upd_en       (w_flag_upd_en),
      .flag_in      (ex_flag),
      .flag_we      (ex_flag_we),
      .flag_clr     (flag_clr),
      .flag_save    (flag_save),
      .flag_restore (flag_restore),
      .ccr          (ccr)
   );

endmodule : ex_mem_stage
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_stage
//  Description : Self-checking bench for ex_mem_stage: directed vector table,
//                hand-written stall/flush and async-reset sequences, and a
//                randomized run against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_mem_stage;

   localparam int DW = 16;
   localparam int AW = 3;

   logic          clk;
   logic          rst;
   logic          ex_valid;
   logic [DW-1:0] ex_result;
   logic [2:0]    ex_flag;
   logic [2:0]    ex_flag_we;
   logic [AW-1:0] ex_rd;
   logic          ex_reg_we;
   logic          ex_mem_rd;
   logic          ex_mem_wr;
   logic [DW-1:0] ex_store_data;
   logic          stall;
   logic          flush;
   logic [2:0]    flag_clr;
   logic          flag_save;
   logic          flag_restore;
   logic          mem_valid;
   logic [DW-1:0] mem_result;
   logic [AW-1:0] mem_rd;
   logic          mem_reg_we;
   logic          mem_mem_rd;
   logic          mem_mem_wr;
   logic [DW-1:0] mem_store_data;
   logic [2:0]    ccr;
   logic          fwd_en;

   ex_mem_stage #(.DATA_W(DW), .RADDR_W(AW)) dut (
      .clk            (clk),
      .rst            (rst),
      .ex_valid       (ex_valid),
      .ex_result      (ex_result),
      .ex_flag        (ex_flag),
      .ex_flag_we     (ex_flag_we),
      .ex_rd          (ex_rd),
      .ex_reg_we      (ex_reg_we),
      .ex_mem_rd      (ex_mem_rd),
      .ex_mem_wr      (ex_mem_wr),
      .ex_store_data  (ex_store_data),
      .stall          (stall),
      .flush          (flush),
      .flag_clr       (flag_clr),
      .flag_save      (flag_save),
      .flag_restore   (flag_restore),
      .mem_valid      (mem_valid),
      .mem_result     (mem_result),
      .mem_rd         (mem_rd),
      .mem_reg_we     (mem_reg_we),
      .mem_mem_rd     (mem_mem_rd),
      .mem_mem_wr     (mem_mem_wr),
      .mem_store_data (mem_store_data),
      .ccr            (ccr),
      .fwd_en         (fwd_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total;
   int n_passed;

   // Reference model state
   logic          m_valid;
   logic [DW-1:0] m_result;
   logic [AW-1:0] m_rd;
   logic          m_reg_we;
   logic          m_mem_rd;
   logic          m_mem_wr;
   logic [DW-1:0] m_store;
   logic [2:0]    m_ccr;
   logic [2:0]    m_saved;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic logic [63:0] dut_vec();
      return {21'd0, mem_valid, mem_result, mem_rd, mem_reg_we, mem_mem_rd,
              mem_mem_wr, mem_store_data, ccr, fwd_en};
   endfunction

   function automatic logic [63:0] model_vec();
      return {21'd0, m_valid, m_result, m_rd, m_reg_we, m_mem_rd,
              m_mem_wr, m_store, m_ccr, m_valid & m_reg_we};
   endfunction

   task automatic model_reset();
      m_valid = 0; m_result = '0; m_rd = '0; m_reg_we = 0;
      m_mem_rd = 0; m_mem_wr = 0; m_store = '0; m_ccr = '0; m_saved = '0;
   endtask

   task automatic idle_inputs();
      ex_valid = 0; ex_result = '0; ex_flag = '0; ex_flag_we = '0; ex_rd = '0;
      ex_reg_we = 0; ex_mem_rd = 0; ex_mem_wr = 0; ex_store_data = '0;
      stall = 0; flush = 0; flag_clr = '0; flag_save = 0; flag_restore = 0;
   endtask

   // Advance the model by one rising edge using the currently driven inputs,
   // then let the DUT take the same edge and settle.
   task automatic tick();
      logic [2:0] nccr;
      logic       accepted;
      accepted = ex_valid && !stall && !flush;
      for (int b = 0; b < 3; b++) begin
         if (flag_restore)                   nccr[b] = m_saved[b];
         else if (accepted && ex_flag_we[b]) nccr[b] = ex_flag[b];
         else if (flag_clr[b])               nccr[b] = 1'b0;
         else                                nccr[b] = m_ccr[b];
      end
      if (flag_save) m_saved = m_ccr;
      m_ccr = nccr;
      if (flush) begin
         m_valid = 0; m_result = '0; m_rd = '0; m_reg_we = 0;
         m_mem_rd = 0; m_mem_wr = 0; m_store = '0;
      end else if (!stall) begin
         m_valid = ex_valid; m_result = ex_result; m_rd = ex_rd;
         m_reg_we = ex_reg_we; m_mem_rd = ex_mem_rd; m_mem_wr = ex_mem_wr;
         m_store = ex_store_data;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      model_reset();
      @(posedge clk);
      #1;
      check("reset_state", dut_vec(), 64'd0);
      rst = 1'b0;
   endtask

   typedef struct {
      logic          v;
      logic [DW-1:0] res;
      logic [2:0]    fl;
      logic [2:0]    we;
      logic [AW-1:0] rd;
      logic          rwe;
      logic          st;
      logic          fsh;
      logic [2:0]    clr;
      logic          sv;
      logic          rs;
      logic          e_valid;
      logic [DW-1:0] e_res;
      logic [AW-1:0] e_rd;
      logic          e_fwd;
      logic [2:0]    e_ccr;
   } vec_t;

   function automatic vec_t mk(logic v, logic [DW-1:0] res, logic [2:0] fl, logic [2:0] we,
                               logic [AW-1:0] rd, logic rwe, logic st, logic fsh,
                               logic [2:0] clr, logic sv, logic rs,
                               logic e_valid, logic [DW-1:0] e_res, logic [AW-1:0] e_rd,
                               logic e_fwd, logic [2:0] e_ccr);
      vec_t t;
      t.v = v; t.res = res; t.fl = fl; t.we = we; t.rd = rd; t.rwe = rwe;
      t.st = st; t.fsh = fsh; t.clr = clr; t.sv = sv; t.rs = rs;
      t.e_valid = e_valid; t.e_res = e_res; t.e_rd = e_rd; t.e_fwd = e_fwd; t.e_ccr = e_ccr;
      return t;
   endfunction

   vec_t tbl[12];

   initial begin
      n_total  = 0;
      n_passed = 0;
      rst      = 1'b1;
      idle_inputs();
      model_reset();

      //            v  res       fl      we      rd rwe st fsh clr     sv rs   ev  eres      erd efwd eccr
      tbl[0]  = mk(1, 16'h1234, 3'b111, 3'b111, 3, 1, 0, 0, 3'b000, 0, 0,   1, 16'h1234, 3, 1, 3'b111);
      tbl[1]  = mk(1, 16'h0000, 3'b000, 3'b001, 0, 0, 0, 0, 3'b100, 0, 0,   1, 16'h0000, 0, 0, 3'b010);
      tbl[2]  = mk(0, 16'h5555, 3'b111, 3'b111, 5, 1, 0, 0, 3'b111, 0, 0,   0, 16'h5555, 5, 0, 3'b000);
      tbl[3]  = mk(1, 16'hAAAA, 3'b111, 3'b111, 7, 1, 1, 0, 3'b000, 0, 0,   0, 16'h5555, 5, 0, 3'b000);
      tbl[4]  = mk(1, 16'h0101, 3'b101, 3'b111, 1, 1, 0, 0, 3'b000, 0, 0,   1, 16'h0101, 1, 1, 3'b101);
      tbl[5]  = mk(1, 16'h0202, 3'b010, 3'b000, 2, 0, 0, 0, 3'b000, 1, 0,   1, 16'h0202, 2, 0, 3'b101);
      tbl[6]  = mk(1, 16'h0303, 3'b010, 3'b111, 3, 1, 0, 0, 3'b000, 0, 0,   1, 16'h0303, 3, 1, 3'b010);
      tbl[7]  = mk(1, 16'h0404, 3'b111, 3'b111, 4, 1, 0, 0, 3'b111, 0, 1,   1, 16'h0404, 4, 1, 3'b101);
      tbl[8]  = mk(1, 16'h0505, 3'b010, 3'b111, 5, 1, 0, 0, 3'b000, 0, 0,   1, 16'h0505, 5, 1, 3'b010);
      tbl[9]  = mk(0, 16'h0000, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 1, 1,   0, 16'h0000, 0, 0, 3'b101);
      tbl[10] = mk(0, 16'h0000, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 1,   0, 16'h0000, 0, 0, 3'b010);
      tbl[11] = mk(1, 16'hFFFF, 3'b111, 3'b111, 6, 1, 1, 0, 3'b010, 0, 0,   0, 16'h0000, 0, 0, 3'b000);

      do_reset();

      // Directed vector table
      for (int i = 0; i < 12; i++) begin
         ex_valid = tbl[i].v; ex_result = tbl[i].res; ex_flag = tbl[i].fl;
         ex_flag_we = tbl[i].we; ex_rd = tbl[i].rd; ex_reg_we = tbl[i].rwe;
         ex_mem_rd = 0; ex_mem_wr = 0; ex_store_data = ~tbl[i].res;
         stall = tbl[i].st; flush = tbl[i].fsh; flag_clr = tbl[i].clr;
         flag_save = tbl[i].sv; flag_restore = tbl[i].rs;
         tick();
         check($sformatf("table[%0d]", i),
               {24'd0, mem_valid, mem_result, mem_rd, fwd_en, ccr},
               {24'd0, tbl[i].e_valid, tbl[i].e_res, tbl[i].e_rd, tbl[i].e_fwd, tbl[i].e_ccr});
         check($sformatf("table_model[%0d]", i), dut_vec(), model_vec());
      end

      // Stall holds, then flush wins over stall
      idle_inputs();
      ex_valid = 1; ex_result = 16'hBEEF; ex_rd = 6; ex_reg_we = 1; ex_mem_wr = 1;
      ex_store_data = 16'h7777;
      tick();
      check("load_beef", {mem_valid, mem_result, mem_rd, fwd_en}, {1'b1, 16'hBEEF, 3'd6, 1'b1});
      stall = 1; ex_result = 16'hCAFE; ex_rd = 2; ex_store_data = 16'h1111;
      for (int k = 0; k < 2; k++) begin
         tick();
         check($sformatf("stall_hold[%0d]", k),
               {mem_valid, mem_result, mem_rd, mem_mem_wr, mem_store_data, fwd_en},
               {1'b1, 16'hBEEF, 3'd6, 1'b1, 16'h7777, 1'b1});
      end
      flush = 1;
      tick();
      check("flush_over_stall", {mem_valid, fwd_en, mem_mem_wr, mem_result},
            {1'b0, 1'b0, 1'b0, 16'h0000});

      // Asynchronous reset mid-stall with valid data and ccr=111
      idle_inputs();
      ex_valid = 1; ex_result = 16'h4321; ex_rd = 1; ex_reg_we = 1;
      ex_flag = 3'b111; ex_flag_we = 3'b111;
      tick();
      check("pre_reset", {mem_valid, ccr, fwd_en}, {1'b1, 3'b111, 1'b1});
      stall = 1;
      tick();
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("async_reset", dut_vec(), 64'd0);
      #2 rst = 1'b0;
      idle_inputs();
      ex_valid = 1; ex_result = 16'h0F0F; ex_rd = 4; ex_reg_we = 1;
      ex_flag = 3'b011; ex_flag_we = 3'b010;
      tick();
      check("after_reset", {mem_valid, mem_result, mem_rd, ccr, fwd_en},
            {1'b1, 16'h0F0F, 3'd4, 3'b010, 1'b1});
      check("after_reset_model", dut_vec(), model_vec());

      // Randomized run against the model
      for (int c = 0; c < 400; c++) begin
         ex_valid      = 1'($urandom_range(0, 1));
         ex_result     = 16'($urandom);
         ex_flag       = 3'($urandom);
         ex_flag_we    = 3'($urandom);
         ex_rd         = 3'($urandom);
         ex_reg_we     = 1'($urandom_range(0, 1));
         ex_mem_rd     = 1'($urandom_range(0, 1));
         ex_mem_wr     = 1'($urandom_range(0, 1));
         ex_store_data = 16'($urandom);
         stall         = ($urandom_range(0, 3) == 0);
         flush         = ($urandom_range(0, 5) == 0);
         flag_clr      = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
         flag_save     = ($urandom_range(0, 7) == 0);
         flag_restore  = ($urandom_range(0, 7) == 0);
         tick();
         check($sformatf("random[%0d]", c), dut_vec(), model_vec());
      end

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule : tb_ex_mem_stage
`default_nettype wire
